// File: rtl/lpc_synth_core.sv
// lpc_synth_core: LPC synthesis engine with double-buffered coefficient
// frames, pulse/noise excitation and a single-multiplier all-pole filter.
// The optional macro LPC_SYNTH_SAT_EN clamps each output sample to the DW
// range; without it the sample wraps in two's complement.
module lpc_synth_core #(
   parameter int ORDER = 10,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int CFRAC = 12,
   parameter int ACCW  = 40
) (
   input  logic                   d_clk,
   input  logic                   d_rst,
   input  logic                   v,
   input  logic [ORDER*CW-1:0]    a_flat,
   input  logic signed [DW-1:0]   gain,
   input  logic                   voiced,
   input  logic [15:0]            pulserate,
   input  logic [15:0]            lpcrate,
   output logic                   ready,
   input  logic                   s_req,
   output logic                   busy,
   output logic signed [DW-1:0]   synth,
   output logic                   vout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXC  = 2'd1;
   localparam logic [1:0] S_MAC  = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   localparam int KW = (ORDER > 1) ? $clog2(ORDER) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(ORDER - 1);

   // Shadow (incoming) frame
   logic signed [CW-1:0] sh_a [ORDER];
   logic signed [DW-1:0] sh_gain;
   logic                 sh_voiced;
   logic [15:0]          sh_pr;
   logic [15:0]          sh_lr;
   logic                 sh_full;

   // Active (in-use) frame
   logic signed [CW-1:0] act_a [ORDER];
   logic signed [DW-1:0] act_gain;
   logic                 act_voiced;
   logic [15:0]          act_pr;
   logic [15:0]          act_lr;
   logic                 act_valid;

   // Sample engine state
   logic [1:0]             state;
   logic [KW-1:0]          k;
   logic signed [ACCW-1:0] acc;
   logic signed [DW-1:0]   exc;
   logic                   run_valid;
   logic signed [DW-1:0]   hist [ORDER];
   logic [15:0]            samp_cnt;
   logic [15:0]            pitch_cnt;
   logic [15:0]            lfsr;

   logic signed [DW-1:0]    e_calc;
   logic signed [CW+DW-1:0] prod;
   logic signed [ACCW-1:0]  acc_next;
   logic signed [DW-1:0]    y_val;
   logic [15:0]             lr_m1;
   logic [15:0]             pr_m1;
   logic                    frame_end;
   logic                    swap;
   logic [15:0]             lfsr_next;

   assign ready = ~sh_full;
   assign busy  = (state != S_IDLE);

   // Frame-period and pitch-period limits, treating a zero rate as one
   always_comb begin
      lr_m1     = (act_lr == 16'd0) ? 16'd0 : act_lr - 16'd1;
      pr_m1     = (act_pr == 16'd0) ? 16'd0 : act_pr - 16'd1;
      frame_end = (samp_cnt >= lr_m1);
      swap      = (state == S_OUT) && run_valid && frame_end;
      lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   // Excitation for the current sample: pitch pulse or signed LFSR noise
   always_comb begin
      e_calc = '0;
      if (act_voiced)
         e_calc = (pitch_cnt == 16'd0) ? act_gain : '0;
      else
         e_calc = lfsr[0] ? act_gain : -act_gain;
   end

   // One tap product per MAC cycle and the resulting filter output
   always_comb begin
      prod     = act_a[k] * hist[k];
      acc_next = acc + {{(ACCW-CW-DW){prod[CW+DW-1]}}, prod};
`ifdef LPC_SYNTH_SAT_EN
      begin
         logic signed [DW+1:0] sum2;
         sum2 = (DW+2)'(exc) + (DW+2)'(acc_next >>> CFRAC);
         if (sum2[DW+1:DW-1] == 3'b000 || sum2[DW+1:DW-1] == 3'b111)
            y_val = sum2[DW-1:0];
         else if (sum2[DW+1])
            y_val = {1'b1, {(DW-1){1'b0}}};
         else
            y_val = {1'b0, {(DW-1){1'b1}}};
      end
`else
      y_val = exc + DW'(acc_next >>> CFRAC);
`endif
   end

   // Frame capture into the shadow and promotion to the active set
   always_ff @(posedge d_clk or posedge d_rst) begin
      if (d_rst) begin
         for (int i = 0; i < ORDER; i++) begin
            sh_a[i]  <= '0;
            act_a[i] <= '0;
         end
         sh_gain    <= '0;
         sh_voiced  <= 1'b0;
         sh_pr      <= '0;
         sh_lr      <= '0;
         sh_full    <= 1'b0;
         act_gain   <= '0;
         act_voiced <= 1'b0;
         act_pr     <= '0;
         act_lr     <= '0;
         act_valid  <= 1'b0;
      end else if (v && !sh_full) begin
         for (int i = 0; i < ORDER; i++)
            sh_a[i] <= a_flat[i*CW +: CW];
         sh_gain   <= gain;
         sh_voiced <= voiced;
         sh_pr     <= pulserate;
         sh_lr     <= lpcrate;
         sh_full   <= 1'b1;
      end else if (sh_full && (!act_valid || swap)) begin
         for (int i = 0; i < ORDER; i++)
            act_a[i] <= sh_a[i];
         act_gain   <= sh_gain;
         act_voiced <= sh_voiced;
         act_pr     <= sh_pr;
         act_lr     <= sh_lr;
         act_valid  <= 1'b1;
         sh_full    <= 1'b0;
      end
   end

   // Sample sequencer: excitation, ORDER MAC cycles, then output/update
   always_ff @(posedge d_clk or posedge d_rst) begin
      if (d_rst) begin
         state     <= S_IDLE;
         k         <= '0;
         acc       <= '0;
         exc       <= '0;
         run_valid <= 1'b0;
         synth     <= '0;
         vout      <= 1'b0;
         for (int i = 0; i < ORDER; i++)
            hist[i] <= '0;
         samp_cnt  <= '0;
         pitch_cnt <= '0;
         lfsr      <= 16'hACE1;
      end else begin
         vout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (s_req)
                  state <= S_EXC;
            end
            S_EXC: begin
               run_valid <= act_valid;
               exc       <= e_calc;
               acc       <= '0;
               k         <= '0;
               state     <= S_MAC;
            end
            S_MAC: begin
               acc <= acc_next;
               if (k == K_LAST) begin
                  synth <= run_valid ? y_val : '0;
                  vout  <= 1'b1;
                  state <= S_OUT;
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: begin
               if (run_valid) begin
                  hist[0] <= synth;
                  for (int i = 1; i < ORDER; i++)
                     hist[i] <= hist[i-1];
                  lfsr      <= lfsr_next;
                  pitch_cnt <= (pitch_cnt >= pr_m1) ? 16'd0 : pitch_cnt + 16'd1;
                  samp_cnt  <= frame_end ? 16'd0 : samp_cnt + 16'd1;
               end
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/lpc_synth_core.md
# lpc_synth_core

Parametrised LPC synthesis engine: the next-generation decoder datapath behind the stream write master. It accepts one coefficient frame per handshake (order, widths and coefficient Q-format set by parameters), generates pitch-pulse or LFSR-noise excitation, and runs a time-multiplexed all-pole filter with a single multiplier. It produces one synthesized sample per `s_req` tick. Frames are double-buffered and swap only on frame boundaries set by `lpcrate`.

## Interface
- ORDER, 10, filter order (number of a_k taps), 1..32
- DW, 16, sample / gain width, signed
- CW, 16, coefficient width, signed
- CFRAC, 12, fractional bits of coefficients
- ACCW, 40, accumulator width, must be >= DW+CW+clog2(ORDER)+1

Ports:
- d_clk  in  1  sole clock, rising edge
- d_rst  in  1  reset, asynchronous, active-high
- v  in  1  coefficient frame valid
- a_flat  in  ORDER*CW  a1..aORDER, signed, a1 in bits [CW-1:0]
- gain  in  DW  excitation amplitude (A0), signed
- voiced  in  1  1 = pulse train, 0 = noise
- pulserate  in  16  pitch period in samples
- lpcrate  in  16  samples per frame
- ready  out  1  shadow buffer empty; frame accepted when v && ready
- s_req  in  1  one-cycle sample request
- busy  out  1  sample computation in progress
- synth  out  DW  synthesized sample, signed, held until next sample
- vout  out  1  one-cycle strobe, synth valid

## Operation
- Frame capture: on v && ready, latch a_flat, gain, voiced, pulserate, lpcrate into the shadow buffer, and set shadow_full (ready=0). v with ready=0 is ignored.
- Active set: if no active frame exists, the shadow moves to active on the next cycle.
- Frame boundary: at the OUT state of a sample with samp_cnt == max(lpcrate,1)-1:
  - samp_cnt wraps to 0.
  - If shadow_full, the shadow moves to active and ready returns to 1 the following cycle.
  - Otherwise the active frame repeats.
- Excitation, evaluated once per sample:
  - voiced: e = gain when pitch_cnt == 0, else 0. pitch_cnt counts modulo max(pulserate,1) and is not reset at frame swap.
  - unvoiced: e = lfsr[0] ? gain : -gain. The LFSR is 16-bit Fibonacci with taps 16,14,13,11 and seed 16'hACE1, and advances once per sample.
- Filter: y[n] = e[n] + (Σ a_k·y[n-k]) >>> CFRAC (arithmetic shift, truncation).
  - The history holds ORDER samples; it shifts only at OUT.
  - The accumulator is ACCW bits, sign-extended.
- FSM:
  - IDLE → EXC on s_req.
  - EXC → MAC: k=1..ORDER, one product per cycle.
  - MAC → OUT after k=ORDER.
  - OUT → IDLE.
- No active frame: s_req still produces synth=0 with vout. History, counters and LFSR stay unchanged.
- s_req while busy is dropped (not queued).

## Timing
- Reset values: synth=0, vout=0, busy=0, ready=1. History, accumulator, samp_cnt and pitch_cnt = 0; lfsr = 16'hACE1; shadow and active frames invalid.
- Latency: s_req at cycle t → vout=1 at cycle t+ORDER+2. busy is high from t+1 to t+ORDER+2 inclusive.
- The minimum s_req spacing for full rate is ORDER+3 cycles.
- A frame handshake at cycle t, with an active frame already present, becomes active no earlier than the next frame boundary.
- v && ready in the same cycle as a boundary swap cannot occur, because ready=0 while shadow_full. A frame accepted at the swap cycle+1 lands in the shadow.
- d_rst asserted mid-sample: immediate return to IDLE with all reset values applied; no vout for the aborted sample.

## Configuration
- LPC_SYNTH_SAT_EN defined: the y[n] sum is computed at DW+2 bits and clamped to [-2^(DW-1), 2^(DW-1)-1]. The clamped value is both output and stored in history.
- LPC_SYNTH_SAT_EN undefined: y[n] is truncated to the low DW bits (two's-complement wrap).

## Test plan
- Reset/idle: assert d_rst, release, pulse s_req → synth=0 and vout pulse at t+ORDER+2; ready=1, busy=0 after reset.
- Impulse response: ORDER=2, CFRAC=12, a1=4096 (1.0), a2=-2048 (-0.5), gain=1000, voiced=1, pulserate=100, lpcrate=240. Eight spaced s_req → synth = 1000, 1000, 500, 0, -250, -250, -125, 0.
- Double buffer: load frame A, then frame B immediately (ready drops). With lpcrate=4, B's coefficients take effect exactly on sample 5; ready returns to 1 one cycle after that swap.
- Noise excitation: voiced=0, all a_k=0, gain=100 → sample sequence ±100 matches the LFSR reference model from seed ACE1 for 64 samples.
- Saturation: a1=8191 (~2.0), gain=30000, voiced=1. With LPC_SYNTH_SAT_EN, synth sticks at 32767; without it, synth wraps negative on the second sample.
- Abort/drop: s_req while busy → no extra vout. d_rst mid-MAC → vout never fires and a subsequent sample matches the post-reset reference.
